// File: rtl/fft_pkg.sv
// Shared constants and drain FSM state type for the FFT frame controller.
package fft_pkg;

    localparam int DATA_WIDTH         = 16;
    localparam int NOF_FFT_POINT      = 64;
    localparam int LOG2_NOF_FFT_POINT = $clog2(NOF_FFT_POINT);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/fft_bin_serializer.sv
// Buffers one FFT result frame and streams its bins out one per handshake.
module fft_bin_serializer #(
    parameter int DW      = 16,
    parameter int N_POINT = 64,
    parameter int BUS_W   = DW * N_POINT,
    parameter int BIN_W   = $clog2(N_POINT)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [BUS_W-1:0] in_real,
    input  logic [BUS_W-1:0] in_imag,
    input  logic             in_valid,
    output logic [DW-1:0]    m_real,
    output logic [DW-1:0]    m_imag,
    output logic [BIN_W-1:0] m_bin,
    output logic             m_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             drop,
    output logic             draining
);
    import fft_pkg::*;

    drain_state_t     state_reg;
    logic [BUS_W-1:0] real_buf_reg;
    logic [BUS_W-1:0] imag_buf_reg;
    logic [DW-1:0]    real_bins [N_POINT];
    logic [DW-1:0]    imag_bins [N_POINT];
    logic [DW-1:0]    m_real_reg;
    logic [DW-1:0]    m_imag_reg;
    logic [BIN_W-1:0] m_bin_reg;
    logic [BIN_W-1:0] bin_next;
    logic             m_last_reg;
    logic             m_valid_reg;
    logic             drop_reg;
    logic             handshake;
    logic             final_hs;
    logic             capture;

    genvar gi;
    generate
        for (gi = 0; gi < N_POINT; gi++) begin : g_bins
            assign real_bins[gi] = real_buf_reg[gi*DW +: DW];
            assign imag_bins[gi] = imag_buf_reg[gi*DW +: DW];
        end
    endgenerate

    assign handshake = m_valid_reg & m_ready;
    assign final_hs  = handshake & m_last_reg;
    // The buffer is free when idle or when its last bin leaves this very cycle.
    assign capture   = in_valid & ((state_reg == ST_IDLE) | final_hs);
    assign bin_next  = m_bin_reg + BIN_W'(1);

    always_ff @(posedge clk) begin
        if (capture) begin
            real_buf_reg <= in_real;
            imag_buf_reg <= in_imag;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg   <= ST_IDLE;
            m_valid_reg <= 1'b0;
            m_bin_reg   <= '0;
            m_last_reg  <= 1'b0;
            m_real_reg  <= '0;
            m_imag_reg  <= '0;
            drop_reg    <= 1'b0;
        end else begin
            drop_reg <= in_valid & ~capture;
            if (capture) begin
                state_reg   <= ST_DRAIN;
                m_valid_reg <= 1'b1;
                m_bin_reg   <= '0;
                m_last_reg  <= (N_POINT == 1);
                m_real_reg  <= in_real[DW-1:0];
                m_imag_reg  <= in_imag[DW-1:0];
            end else begin
                case (state_reg)
                    ST_DRAIN: begin
                        if (final_hs) begin
                            state_reg   <= ST_IDLE;
                            m_valid_reg <= 1'b0;
                            m_bin_reg   <= '0;
                            m_last_reg  <= 1'b0;
                        end else if (handshake) begin
                            m_bin_reg  <= bin_next;
                            m_last_reg <= (bin_next == BIN_W'(N_POINT - 1));
                            m_real_reg <= real_bins[bin_next];
                            m_imag_reg <= imag_bins[bin_next];
                        end
                    end
                    default: begin
                        m_valid_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign m_real   = m_real_reg;
    assign m_imag   = m_imag_reg;
    assign m_bin    = m_bin_reg;
    assign m_last   = m_last_reg;
    assign m_valid  = m_valid_reg;
    assign drop     = drop_reg;
    assign draining = (state_reg == ST_DRAIN);

endmodule

// File: rtl/fft_frame_ctrl.sv
// Collects samples into parallel FFT frames and serializes FFT results into a bin stream.
module fft_frame_ctrl #(
    parameter int DATA_WIDTH     = fft_pkg::DATA_WIDTH,
    parameter int NOF_FFT_POINT  = fft_pkg::NOF_FFT_POINT,
    parameter int DATA_BUS_WIDTH = DATA_WIDTH * NOF_FFT_POINT
) (
    input  logic                              clk_data,
    input  logic                              rst,
    input  logic                              en,
    input  logic [DATA_WIDTH-1:0]             s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic [DATA_BUS_WIDTH-1:0]         fft_data_in,
    output logic                              fft_data_in_valid,
    input  logic [DATA_BUS_WIDTH-1:0]         fft_data_out_real,
    input  logic [DATA_BUS_WIDTH-1:0]         fft_data_out_imag,
    input  logic                              fft_data_out_valid,
    output logic [DATA_WIDTH-1:0]             m_real,
    output logic [DATA_WIDTH-1:0]             m_imag,
    output logic [$clog2(NOF_FFT_POINT)-1:0]  m_bin,
    output logic                              m_last,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [15:0]                       frame_cnt,
    output logic                              frame_drop,
    output logic                              busy
);
    localparam int IDX_W = $clog2(NOF_FFT_POINT);

    logic [IDX_W-1:0]          wr_idx_reg;
    logic [DATA_WIDTH-1:0]     collect_reg [NOF_FFT_POINT];
    logic [DATA_BUS_WIDTH-1:0] launch_reg;
    logic [DATA_BUS_WIDTH-1:0] frame_next;
    logic                      launch_valid_reg;
    logic [15:0]               frame_cnt_reg;
    logic [3:0]                inflight_reg;
    logic                      accept;
    logic                      frame_done;
    logic                      draining;

    assign s_ready    = en;
    assign accept     = s_valid & en;
    assign frame_done = accept & (wr_idx_reg == IDX_W'(NOF_FFT_POINT - 1));

    // The closing sample bypasses the collect register so the frame launches without a bubble.
    genvar gi;
    generate
        for (gi = 0; gi < NOF_FFT_POINT; gi++) begin : g_frame
            if (gi == NOF_FFT_POINT - 1) begin : g_tail
                assign frame_next[gi*DATA_WIDTH +: DATA_WIDTH] = s_data;
            end else begin : g_body
                assign frame_next[gi*DATA_WIDTH +: DATA_WIDTH] = collect_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk_data) begin
        if (accept) begin
            collect_reg[wr_idx_reg] <= s_data;
        end
    end

    always_ff @(posedge clk_data) begin
        if (rst) begin
            wr_idx_reg       <= '0;
            launch_reg       <= '0;
            launch_valid_reg <= 1'b0;
            frame_cnt_reg    <= '0;
        end else begin
            launch_valid_reg <= frame_done;
            if (!en || frame_done) begin
                wr_idx_reg <= '0;
            end else if (accept) begin
                wr_idx_reg <= wr_idx_reg + IDX_W'(1);
            end
            if (frame_done) begin
                launch_reg    <= frame_next;
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_data) begin
        if (rst) begin
            inflight_reg <= '0;
        end else begin
            case ({frame_done, fft_data_out_valid})
                2'b10:   if (inflight_reg != 4'd15) inflight_reg <= inflight_reg + 4'd1;
                2'b01:   if (inflight_reg != 4'd0)  inflight_reg <= inflight_reg - 4'd1;
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

    fft_bin_serializer #(
        .DW      (DATA_WIDTH),
        .N_POINT (NOF_FFT_POINT),
        .BUS_W   (DATA_BUS_WIDTH),
        .BIN_W   (IDX_W)
    ) u_serializer (
        .clk      (clk_data),
        .srst     (rst),
        .in_real  (fft_data_out_real),
        .in_imag  (fft_data_out_imag),
        .in_valid (fft_data_out_valid),
        .m_real   (m_real),
        .m_imag   (m_imag),
        .m_bin    (m_bin),
        .m_last   (m_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .drop     (frame_drop),
        .draining (draining)
    );

    assign fft_data_in       = launch_reg;
    assign fft_data_in_valid = launch_valid_reg;
    assign frame_cnt         = frame_cnt_reg;
    assign busy              = (inflight_reg != 4'd0) | draining;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed and randomized bench for fft_frame_ctrl against a frame/bin-stream reference model.
module tb_fft_frame_ctrl;
    localparam int DW   = 16;
    localparam int N    = 64;
    localparam int BUSW = DW * N;
    localparam int BW   = 6;

    logic            clk_data = 1'b0;
    logic            rst;
    logic            en;
    logic [DW-1:0]   s_data;
    logic            s_valid;
    logic            s_ready;
    logic [BUSW-1:0] fft_data_in;
    logic            fft_data_in_valid;
    logic [BUSW-1:0] fft_data_out_real;
    logic [BUSW-1:0] fft_data_out_imag;
    logic            fft_data_out_valid;
    logic [DW-1:0]   m_real;
    logic [DW-1:0]   m_imag;
    logic [BW-1:0]   m_bin;
    logic            m_last;
    logic            m_valid;
    logic            m_ready;
    logic [15:0]     frame_cnt;
    logic            frame_drop;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int launches = 0;
    int inflight_exp = 0;
    int frames_exp = 0;
    int l0;
    logic [DW-1:0]   acc_q [$];
    logic [DW-1:0]   cur_re [N];
    logic [DW-1:0]   cur_im [N];
    logic [DW-1:0]   nxt_re [N];
    logic [DW-1:0]   nxt_im [N];
    logic [BUSW-1:0] launch_exp;

    fft_frame_ctrl dut (
        .clk_data           (clk_data),
        .rst                (rst),
        .en                 (en),
        .s_data             (s_data),
        .s_valid            (s_valid),
        .s_ready            (s_ready),
        .fft_data_in        (fft_data_in),
        .fft_data_in_valid  (fft_data_in_valid),
        .fft_data_out_real  (fft_data_out_real),
        .fft_data_out_imag  (fft_data_out_imag),
        .fft_data_out_valid (fft_data_out_valid),
        .m_real             (m_real),
        .m_imag             (m_imag),
        .m_bin              (m_bin),
        .m_last             (m_last),
        .m_valid            (m_valid),
        .m_ready            (m_ready),
        .frame_cnt          (frame_cnt),
        .frame_drop         (frame_drop),
        .busy               (busy)
    );

    always #5 clk_data = ~clk_data;

    always @(negedge clk_data) begin
        if (fft_data_in_valid === 1'b1) launches++;
    end

    task automatic chk(input string tag, input logic [BUSW-1:0] obs, input logic [BUSW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Feeds n accepted samples; the model launches a frame whenever 64 accepts have queued up.
    task automatic feed(input int n, input bit rand_data, input bit gaps);
        int sent;
        logic [DW-1:0] v;
        sent = 0;
        while (sent < n) begin
            v       = rand_data ? DW'($urandom) : DW'(sent);
            s_data  = v;
            s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk_data);
            if (s_valid && en) begin
                acc_q.push_back(v);
                sent++;
            end
            #1;
            if (acc_q.size() == N) begin
                for (int k = 0; k < N; k++) launch_exp[k*DW +: DW] = acc_q[k];
                frames_exp++;
                if (inflight_exp < 15) inflight_exp++;
                chk("launch_valid", BUSW'(fft_data_in_valid), BUSW'(1));
                chk("launch_frame", fft_data_in, launch_exp);
                chk("frame_cnt", BUSW'(frame_cnt), BUSW'(frames_exp & 16'hffff));
                acc_q.delete();
            end else begin
                chk("no_launch", BUSW'(fft_data_in_valid), BUSW'(0));
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic load_bus();
        for (int k = 0; k < N; k++) begin
            fft_data_out_real[k*DW +: DW] = nxt_re[k];
            fft_data_out_imag[k*DW +: DW] = nxt_im[k];
        end
    endtask

    task automatic pulse_result();
        load_bus();
        fft_data_out_valid = 1'b1;
        @(posedge clk_data);
        #1;
        fft_data_out_valid = 1'b0;
        if (inflight_exp > 0) inflight_exp--;
        for (int k = 0; k < N; k++) begin
            cur_re[k] = nxt_re[k];
            cur_im[k] = nxt_im[k];
        end
        chk("capture_drop", BUSW'(frame_drop), BUSW'(0));
    endtask

    task automatic randomize_next();
        for (int k = 0; k < N; k++) begin
            nxt_re[k] = DW'($urandom);
            nxt_im[k] = DW'($urandom);
        end
    endtask

    // Drains the current frame; every sampled cycle must show the bin the model expects next.
    task automatic drain(input bit toggle, input int inject_bin, input bit inject_last, input int stop_bin);
        int beat;
        int cyc;
        bit inj;
        bit injected;
        beat = 0;
        cyc = 0;
        injected = 0;
        while (beat < N && cyc < 600) begin
            if (stop_bin >= 0 && beat == stop_bin) break;
            chk("m_valid", BUSW'(m_valid), BUSW'(1));
            chk("m_bin", BUSW'(m_bin), BUSW'(beat));
            chk("m_real", BUSW'(m_real), BUSW'(cur_re[beat]));
            chk("m_imag", BUSW'(m_imag), BUSW'(cur_im[beat]));
            chk("m_last", BUSW'(m_last), BUSW'(beat == N - 1));
            m_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            inj = 0;
            if (inject_bin == beat && !injected) begin
                for (int w = 0; w < BUSW / 32; w++) begin
                    fft_data_out_real[w*32 +: 32] = $urandom;
                    fft_data_out_imag[w*32 +: 32] = $urandom;
                end
                fft_data_out_valid = 1'b1;
                injected = 1;
                inj = 1;
            end
            if (inject_last && beat == N - 1 && m_ready) begin
                load_bus();
                fft_data_out_valid = 1'b1;
            end
            @(posedge clk_data);
            #1;
            if (fft_data_out_valid && inflight_exp > 0) inflight_exp--;
            fft_data_out_valid = 1'b0;
            cyc++;
            if (m_ready) beat++;
            chk("frame_drop", BUSW'(frame_drop), BUSW'(inj));
        end
        m_ready = 1'b0;
        chk("drain_beats", BUSW'(beat), BUSW'(stop_bin >= 0 ? stop_bin : N));
        if (stop_bin < 0) begin
            chk("drain_cycles", BUSW'(cyc), BUSW'(toggle ? 2 * N - 1 : N));
            if (inject_last) begin
                for (int k = 0; k < N; k++) begin
                    cur_re[k] = nxt_re[k];
                    cur_im[k] = nxt_im[k];
                end
                chk("recapture_valid", BUSW'(m_valid), BUSW'(1));
                chk("recapture_bin", BUSW'(m_bin), BUSW'(0));
            end else begin
                chk("drain_end_valid", BUSW'(m_valid), BUSW'(0));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        s_data = '0;
        s_valid = 1'b0;
        fft_data_out_real = '0;
        fft_data_out_imag = '0;
        fft_data_out_valid = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk_data);
        #1;
        chk("rst_m_valid", BUSW'(m_valid), BUSW'(0));
        chk("rst_launch_valid", BUSW'(fft_data_in_valid), BUSW'(0));
        chk("rst_launch_reg", fft_data_in, BUSW'(0));
        chk("rst_frame_cnt", BUSW'(frame_cnt), BUSW'(0));
        chk("rst_busy", BUSW'(busy), BUSW'(0));
        chk("rst_m_bin", BUSW'(m_bin), BUSW'(0));
        chk("rst_s_ready", BUSW'(s_ready), BUSW'(0));
        rst = 1'b0;
        en = 1'b1;
        #1;
        chk("s_ready_en", BUSW'(s_ready), BUSW'(1));

        // Ramp frame: slot k holds k.
        feed(N, 1'b0, 1'b0);
        chk("busy_inflight", BUSW'(busy), BUSW'(1));
        @(posedge clk_data);
        #1;
        chk("launch_one_cycle", BUSW'(fft_data_in_valid), BUSW'(0));
        chk("launch_hold", fft_data_in, launch_exp);

        // Random samples with valid gaps.
        feed(N, 1'b1, 1'b1);

        // Partial frame discarded by en low, then a fresh frame.
        feed(30, 1'b1, 1'b0);
        en = 1'b0;
        #1;
        chk("s_ready_off", BUSW'(s_ready), BUSW'(0));
        @(posedge clk_data);
        #1;
        acc_q.delete();
        en = 1'b1;
        l0 = launches;
        feed(N, 1'b1, 1'b1);
        @(posedge clk_data);
        #1;
        chk("fresh_launch_count", BUSW'(launches - l0), BUSW'(1));

        // Ramp result: real = k, imag = -k, full-rate drain.
        for (int k = 0; k < N; k++) begin
            nxt_re[k] = DW'(k);
            nxt_im[k] = DW'(-k);
        end
        pulse_result();
        drain(1'b0, -1, 1'b0, -1);

        // Random result with m_ready toggling.
        randomize_next();
        pulse_result();
        drain(1'b1, -1, 1'b0, -1);

        // Result dropped mid-drain, then one captured on the final handshake.
        randomize_next();
        pulse_result();
        randomize_next();
        drain(1'b0, 10, 1'b1, -1);
        drain(1'b0, -1, 1'b0, -1);
        chk("busy_after_drains", BUSW'(busy), BUSW'(inflight_exp != 0));

        // Reset in the middle of a drain.
        feed(N, 1'b1, 1'b0);
        randomize_next();
        pulse_result();
        drain(1'b0, -1, 1'b0, 20);
        rst = 1'b1;
        @(posedge clk_data);
        #1;
        rst = 1'b0;
        frames_exp = 0;
        inflight_exp = 0;
        chk("midrst_m_valid", BUSW'(m_valid), BUSW'(0));
        chk("midrst_m_bin", BUSW'(m_bin), BUSW'(0));
        chk("midrst_frame_cnt", BUSW'(frame_cnt), BUSW'(frames_exp));
        chk("midrst_busy", BUSW'(busy), BUSW'(0));
        chk("midrst_launch_reg", fft_data_in, BUSW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
